// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA byte-stream loader.
package rsa_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        DRAIN
    } loader_state_t;

    function automatic int unsigned nbytes(input int unsigned width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/rsa_byte_serializer.sv
// Parallel WIDTH-bit load, then an MSB-first byte stream with valid/ready handshake.
module rsa_byte_serializer
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              last_xfer_c
);

    localparam int unsigned NBYTES = nbytes(WIDTH);
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             xfer;

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        xfer        = valid_q && out_ready_i;
        last_xfer_c = xfer && (cnt_q == CNT_W'(1));
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = CNT_W'(NBYTES);
            valid_d = 1'b1;
        end else if (xfer) begin
            shift_d = {shift_q[WIDTH-BYTE_W-1:0], {BYTE_W{1'b0}}};
            cnt_d   = cnt_q - CNT_W'(1);
            valid_d = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = shift_q[WIDTH-1 -: BYTE_W];

endmodule

// File: rtl/rsa_block_loader.sv
// Byte-stream front/back end for the modexp core: assembles blocks, issues jobs, drains results.
// Optional RSA_RANGE_CHECK_EN: drop blocks with m >= n and pulse blk_err instead of issuing.
module rsa_block_loader
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr,
    input  logic [WIDTH-1:0]  key_e,
    input  logic [WIDTH-1:0]  key_n,
    output logic              key_valid,
    output logic              key_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              busy,
    output logic              blk_err,
    output logic              mx_go,
    output logic [WIDTH-1:0]  mx_m,
    output logic [WIDTH-1:0]  mx_e,
    output logic [WIDTH-1:0]  mx_n,
    input  logic [WIDTH-1:0]  mx_result,
    input  logic              mx_done
);

    localparam int unsigned NBYTES = nbytes(WIDTH);
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [WIDTH-1:0] blk_q, blk_d;
    logic [WIDTH-1:0] key_e_q, key_e_d;
    logic [WIDTH-1:0] key_n_q, key_n_d;
    logic             key_valid_q, key_valid_d;
    logic             key_err_q, key_err_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             mx_go_q, mx_go_d;
    logic             blk_err_q, blk_err_d;

    logic             in_xfer;
    logic             range_ok;
    logic [WIDTH-1:0] blk_nxt;
    logic             ser_load;
    logic             ser_last_c;

    // Next-state, key handling and block assembly
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        blk_d       = blk_q;
        key_e_d     = key_e_q;
        key_n_d     = key_n_q;
        key_valid_d = key_valid_q;
        key_err_d   = 1'b0;
        mx_go_d     = 1'b0;
        blk_err_d   = 1'b0;
        ser_load    = 1'b0;
        in_xfer     = in_valid && in_ready_q;
        blk_nxt     = {blk_q[WIDTH-BYTE_W-1:0], in_data};
`ifdef RSA_RANGE_CHECK_EN
        range_ok    = (blk_nxt < key_n_q);
`else
        range_ok    = 1'b1;
`endif

        unique case (state_q)
            LOAD: begin
                if (key_wr && (in_cnt_q == '0)) begin
                    if (key_n < WIDTH'(2)) begin
                        key_err_d   = 1'b1;
                        key_valid_d = 1'b0;
                    end else begin
                        key_e_d     = key_e;
                        key_n_d     = key_n;
                        key_valid_d = 1'b1;
                    end
                end
                if (in_xfer) begin
                    blk_d = blk_nxt;
                    if (in_cnt_q == CNT_W'(NBYTES - 1)) begin
                        in_cnt_d  = '0;
                        state_d   = ISSUE;
                        // go/err are decided here so both are registered into ISSUE
                        mx_go_d   = range_ok;
                        blk_err_d = !range_ok;
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end
                end
            end
            ISSUE:   state_d = mx_go_q ? WAIT : LOAD;
            WAIT: begin
                if (mx_done) begin
                    ser_load = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (ser_last_c) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        in_ready_d = (state_d == LOAD) && key_valid_d;
        busy_d     = (state_d != LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            in_cnt_q    <= '0;
            blk_q       <= '0;
            key_e_q     <= '0;
            key_n_q     <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            mx_go_q     <= 1'b0;
            blk_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            blk_q       <= blk_d;
            key_e_q     <= key_e_d;
            key_n_q     <= key_n_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            mx_go_q     <= mx_go_d;
            blk_err_q   <= blk_err_d;
        end
    end

    rsa_byte_serializer #(
        .WIDTH(WIDTH)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ser_load),
        .data_i     (mx_result),
        .out_ready_i(out_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .last_xfer_c(ser_last_c)
    );

    // Key and block registers only change in LOAD, so operands hold through a job
    assign mx_m      = blk_q;
    assign mx_e      = key_e_q;
    assign mx_n      = key_n_q;
    assign mx_go     = mx_go_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign blk_err   = blk_err_q;

endmodule

// File: tb/tb_rsa_block_loader.sv
// Self-checking bench for rsa_block_loader with a behavioural modexp responder.
module tb_rsa_block_loader;

    localparam int unsigned W  = 32;
    localparam int unsigned NB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_wr = 1'b0;
    logic [W-1:0] key_e = '0;
    logic [W-1:0] key_n = '0;
    logic         key_valid, key_err;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic         busy, blk_err, mx_go;
    logic [W-1:0] mx_m, mx_e, mx_n;
    logic [W-1:0] mx_result = '0;
    logic         mx_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int resp_lat = 4;
    int go_count = 0;
    int exp_go   = 0;
    int stale_req = 0;
    int stale_ack = 0;
    bit range_chk;

    bit           pend = 1'b0;
    int           cnt  = 0;
    logic [W-1:0] r_m, r_e, r_n;

    always #5 clk = ~clk;

    rsa_block_loader #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .key_wr(key_wr), .key_e(key_e), .key_n(key_n),
        .key_valid(key_valid), .key_err(key_err), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .blk_err(blk_err), .mx_go(mx_go), .mx_m(mx_m), .mx_e(mx_e), .mx_n(mx_n),
        .mx_result(mx_result), .mx_done(mx_done)
    );

    // Reference modular exponentiation: square-and-multiply on 64-bit intermediates
    function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] n);
        logic [63:0] r, x, nn;
        nn = {32'd0, n};
        r  = 64'd1 % nn;
        x  = {32'd0, b} % nn;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[W-1:0];
    endfunction

    // Behavioural modexp core: captures on go, answers after resp_lat cycles
    always @(posedge clk) begin
        #1;
        mx_done = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (stale_req != stale_ack) begin
            stale_ack = stale_req;
            mx_done   = 1'b1;
            mx_result = $urandom;
        end else if (pend) begin
            if (cnt == 0) begin
                mx_done   = 1'b1;
                mx_result = modpow(r_m, r_e, r_n);
                pend      = 1'b0;
            end else begin
                cnt--;
            end
        end else if (mx_go) begin
            pend = 1'b1;
            cnt  = resp_lat;
            r_m  = mx_m;
            r_e  = mx_e;
            r_n  = mx_n;
            go_count++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_key(input logic [W-1:0] e, input logic [W-1:0] n);
        @(negedge clk);
        key_wr = 1'b1; key_e = e; key_n = n;
        @(negedge clk);
        key_wr = 1'b0;
        if (n < 2) begin
            check("key_err_set", 64'(key_err), 64'd1);
            check("key_valid_bad", 64'(key_valid), 64'd0);
            check("in_ready_bad", 64'(in_ready), 64'd0);
        end else begin
            check("key_err_clr", 64'(key_err), 64'd0);
            check("key_valid_ok", 64'(key_valid), 64'd1);
            check("in_ready_ok", 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        check("key_err_pulse", 64'(key_err), 64'd0);
    endtask

    task automatic send_block(input logic [W-1:0] m);
        for (int i = 0; i < NB; i++) begin
            int  budget;
            bit  acc;
            bit  got;
            budget = 50;
            got    = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = m[31 - 8*i -: 8];
            while (!got) begin
                acc = in_ready;
                @(negedge clk);
                if (acc) got = 1'b1;
                else if (--budget == 0) begin
                    check("in_ready_timeout", 64'd0, 64'd1);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // mode: 0 ready always high, 1 pattern 1-0-0-1, 2 random
    task automatic run_block(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                             input logic [W-1:0] want, input int mode, input bit spurious);
        bit   drop;
        int   budget;
        int   k;
        int   cyc;
        bit   prev_stall;
        logic [7:0] prev_data;
        bit   pat [4];
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        drop = range_chk && (m >= n);
        send_block(m);
        if (drop) begin
            check("drop_no_go", 64'(mx_go), 64'd0);
            check("drop_blk_err", 64'(blk_err), 64'd1);
            @(negedge clk);
            check("drop_blk_err_pulse", 64'(blk_err), 64'd0);
            check("drop_back_to_load", 64'({busy, in_ready}), 64'b01);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("drop_no_output", 64'({out_valid, mx_go}), 64'd0);
            end
            return;
        end
        exp_go++;
        check("go_latency", 64'(mx_go), 64'd1);
        check("go_blk_err", 64'(blk_err), 64'd0);
        check("go_mx_m", 64'(mx_m), 64'(m));
        check("go_mx_e", 64'(mx_e), 64'(e));
        check("go_mx_n", 64'(mx_n), 64'(n));
        @(negedge clk);
        check("go_one_cycle", 64'(mx_go), 64'd0);
        if (spurious) begin
            key_wr = 1'b1; key_e = ~e; key_n = n ^ 32'h5;
            @(negedge clk);
            key_wr = 1'b0;
            check("spur_no_key_err", 64'(key_err), 64'd0);
        end
        budget = 100;
        while (!mx_done && budget > 0) begin
            check("no_early_out", 64'(out_valid), 64'd0);
            @(negedge clk);
            budget--;
        end
        check("mx_done_seen", 64'(mx_done), 64'd1);
        check("hold_mx_e", 64'(mx_e), 64'(e));
        check("hold_mx_n", 64'(mx_n), 64'(n));
        check("hold_mx_m", 64'(mx_m), 64'(m));
        @(negedge clk);
        check("out_latency", 64'(out_valid), 64'd1);
        k = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (k < NB && cyc < 200) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = pat[cyc % 4];
            else out_ready = 1'($urandom_range(0, 1));
            if (prev_stall) check("out_hold", 64'({out_valid, out_data}), 64'({1'b1, prev_data}));
            if (out_valid && out_ready) begin
                check("out_byte", 64'(out_data), 64'(want[31 - 8*k -: 8]));
                k++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = out_valid;
                prev_data  = out_data;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("out_count", 64'(k), 64'(NB));
        check("post_drain", 64'({in_ready, out_valid, busy, key_valid}), 64'b1001);
    endtask

    initial begin
        logic [W-1:0] re, rn, rm;
`ifdef RSA_RANGE_CHECK_EN
        range_chk = 1'b1;
`else
        range_chk = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outputs", 64'({key_valid, key_err, in_ready, out_valid, busy, blk_err, mx_go}), 64'd0);
        check("rst_mx_n", 64'(mx_n), 64'd0);
        check("rst_mx_e", 64'(mx_e), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Illegal then legal key
        write_key(32'd17, 32'd1);
        write_key(32'd17, 32'd3233);

        // Encrypt, decrypt, stalled drain
        run_block(32'h0000_0041, 32'd17, 32'd3233, 32'd2790, 0, 1'b0);
        write_key(32'd2753, 32'd3233);
        run_block(32'h0000_0AE6, 32'd2753, 32'd3233, 32'd65, 0, 1'b0);
        write_key(32'd17, 32'd3233);
        run_block(32'h0000_0041, 32'd17, 32'd3233, 32'd2790, 1, 1'b1);

        // e = 0 gives 1; m == n either dropped or reduced to 0
        write_key(32'd0, 32'd3233);
        run_block(32'd5, 32'd0, 32'd3233, 32'd1, 2, 1'b0);
        write_key(32'd17, 32'd3233);
        run_block(32'h0000_0CA1, 32'd17, 32'd3233, 32'd0, 2, 1'b0);

        // Reset while waiting on modexp, then stale done must be ignored
        resp_lat = 30;
        send_block(32'h0000_0041);
        exp_go++;
        check("wait_go", 64'(mx_go), 64'd1);
        repeat (2) @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", 64'({busy, out_valid, key_valid, in_ready, mx_go}), 64'd0);
        stale_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stale_done_ignored", 64'({busy, out_valid}), 64'd0);
        end
        resp_lat = 4;

        // Randomised blocks against the reference model
        for (int t = 0; t < 8; t++) begin
            re = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            rn = 32'($urandom) | 32'h2;
            rm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom) % rn;
            resp_lat = $urandom_range(2, 9);
            write_key(re, rn);
            run_block(rm, re, rn, modpow(rm, re, rn), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (12) @(negedge clk);
        check("go_count", 64'(go_count), 64'(exp_go));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
